// File: rtl/shifter_operand_ctrl_if.sv
// Handshake and data bundle between the shifter operand sequencer, the
// control unit, the register-file read port and the BarrelShifter.
// The master side is the surrounding datapath; the slave side is the sequencer.
interface shifter_operand_ctrl_if;
    logic        Start;
    logic [31:0] IR_In;
    logic        SR29_In;
    logic [31:0] PC_In;
    logic        RF_Req;
    logic [3:0]  RF_Addr;
    logic        RF_Ack;
    logic [31:0] RF_Data;
    logic [31:0] BS_Rs;
    logic [31:0] BS_Rm;
    logic [31:0] BS_IR;
    logic        BS_SR29_IN;
    logic [31:0] BS_Out;
    logic        BS_SR29_OUT;
    logic [31:0] Operand;
    logic        CarryOut;
    logic        Done;
    logic        Error;
    logic        Busy;

    modport master (
        output Start, IR_In, SR29_In, PC_In, RF_Ack, RF_Data, BS_Out, BS_SR29_OUT,
        input  RF_Req, RF_Addr, BS_Rs, BS_Rm, BS_IR, BS_SR29_IN,
               Operand, CarryOut, Done, Error, Busy
    );

    modport slave (
        input  Start, IR_In, SR29_In, PC_In, RF_Ack, RF_Data, BS_Out, BS_SR29_OUT,
        output RF_Req, RF_Addr, BS_Rs, BS_Rm, BS_IR, BS_SR29_IN,
               Operand, CarryOut, Done, Error, Busy
    );
endinterface

// File: rtl/shifter_operand_ctrl.sv
// Shifter operand sequencer: latches the instruction on Start, fetches Rm and
// optionally Rs over the single register-file read port (r15 reads return the
// pipelined PC), lets the external BarrelShifter work for one cycle and
// registers its result and carry for the execute stage.
module shifter_operand_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter logic [31:0] PC_OFFSET   = 32'd8
) (
    input logic Clk,
    input logic Reset,
    shifter_operand_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        READ_RM,
        READ_RS,
        SHIFT,
        DONE
    } state_t;

    // Last timer value before the read is abandoned; a read therefore keeps
    // RF_Req up for exactly ACK_TIMEOUT cycles when no Ack ever arrives.
    localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [31:0] ir_q;
    logic        c_q;
    logic [31:0] pc_q;
    logic [31:0] rm_q;
    logic [31:0] rs_q;
    logic [7:0]  timer;
    logic [31:0] operand_q;
    logic        carry_q;
    logic        done_q;
    logic        error_q;

    logic        in_read;
    logic [3:0]  rd_index;
    logic        rd_is_pc;
    logic        rd_done;
    logic        rd_timeout;
    logic [31:0] rd_value;

    // Decode the current register read: which index, whether it is the PC
    // shortcut, and whether it completes or times out this cycle.
    always_comb begin
        in_read    = (state == READ_RM) || (state == READ_RS);
        rd_index   = (state == READ_RS) ? ir_q[11:8] : ir_q[3:0];
        rd_is_pc   = (rd_index == 4'hF);
        rd_done    = in_read && (rd_is_pc || bus.RF_Ack);
        rd_timeout = in_read && !rd_is_pc && !bus.RF_Ack && (timer == TIMER_LAST);
        rd_value   = rd_is_pc ? (pc_q + PC_OFFSET) : bus.RF_Data;
    end

    assign bus.RF_Req     = in_read && !rd_is_pc;
    assign bus.RF_Addr    = bus.RF_Req ? rd_index : 4'h0;
    assign bus.BS_IR      = ir_q;
    assign bus.BS_Rm      = rm_q;
    assign bus.BS_Rs      = rs_q;
    assign bus.BS_SR29_IN = c_q;
    assign bus.Operand    = operand_q;
    assign bus.CarryOut   = carry_q;
    assign bus.Done       = done_q;
    assign bus.Error      = error_q;
    assign bus.Busy       = (state != IDLE);

    // Sequencer: accept Start only in IDLE, walk through the reads, capture the
    // shifter result and pulse Done for one cycle; a stalled read ends in DONE
    // with Error set and a zero operand.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            ir_q      <= '0;
            c_q       <= 1'b0;
            pc_q      <= '0;
            rm_q      <= '0;
            rs_q      <= '0;
            timer     <= '0;
            operand_q <= '0;
            carry_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        ir_q  <= bus.IR_In;
                        c_q   <= bus.SR29_In;
                        pc_q  <= bus.PC_In;
                        timer <= '0;
                        if (bus.IR_In[25]) begin
                            rm_q  <= '0;
                            rs_q  <= '0;
                            state <= SHIFT;
                        end else begin
                            state <= READ_RM;
                        end
                    end
                end
                READ_RM, READ_RS: begin
                    if (rd_done) begin
                        timer <= '0;
                        if (state == READ_RS) begin
                            rs_q  <= rd_value;
                            state <= SHIFT;
                        end else begin
                            rm_q <= rd_value;
                            if (ir_q[4]) begin
                                state <= READ_RS;
                            end else begin
                                rs_q  <= '0;
                                state <= SHIFT;
                            end
                        end
                    end else if (rd_timeout) begin
                        operand_q <= '0;
                        carry_q   <= c_q;
                        error_q   <= 1'b1;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                SHIFT: begin
                    operand_q <= bus.BS_Out;
                    carry_q   <= bus.BS_SR29_OUT;
                    error_q   <= 1'b0;
                    done_q    <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_operand_ctrl.sv
// Bench for the shifter operand sequencer: a register-file responder with a
// programmable Ack delay, a behavioural BarrelShifter, a table of operations
// and hand-written sequences for timeout, Start-while-busy and mid-op reset.
module tb_shifter_operand_ctrl;

    localparam int ACK_TIMEOUT = 15;

    typedef struct {
        logic [31:0] ir;
        logic        c;
        logic [31:0] pc;
        int          ack_delay;
        logic [31:0] exp_operand;
        logic        exp_carry;
        logic        exp_error;
        int          exp_latency;
        int          exp_req;
        int          n_addr;
        logic [3:0]  addr0;
        logic [3:0]  addr1;
    } vec_t;

    typedef struct {
        logic [31:0] operand;
        logic        carry;
        logic        error;
        int          latency;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;

    shifter_operand_ctrl_if bus ();

    shifter_operand_ctrl #(
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .PC_OFFSET  (32'd8)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    logic [31:0] regs [16];
    vec_t        vecs [7];
    vec_t        tmo_vec;
    exp_t        sb [$];
    logic [3:0]  addr_log [$];
    int          ack_delay;
    bit          ack_enable;
    int          passed;
    int          total;

    // Behavioural BarrelShifter: immediate rotate or register shift by
    // immediate/Rs amount, returning {carry, result}.
    function automatic logic [32:0] bs_model(input logic [31:0] ir, input logic [31:0] rm,
                                             input logic [31:0] rs, input logic cin);
        logic [31:0] res;
        logic [31:0] imm;
        logic        c;
        int          amt;
        int          rot;
        res = rm;
        c   = cin;
        if (ir[25]) begin
            imm = {24'b0, ir[7:0]};
            rot = int'(ir[11:8]) * 2;
            if (rot == 0) begin
                res = imm;
                c   = cin;
            end else begin
                res = (imm >> rot) | (imm << (32 - rot));
                c   = res[31];
            end
        end else begin
            amt = ir[4] ? int'(rs[7:0]) : int'(ir[11:7]);
            if (amt != 0) begin
                case (ir[6:5])
                    2'b00: begin
                        if (amt < 32) begin res = rm << amt; c = rm[32 - amt]; end
                        else begin res = '0; c = (amt == 32) ? rm[0] : 1'b0; end
                    end
                    2'b01: begin
                        if (amt < 32) begin res = rm >> amt; c = rm[amt - 1]; end
                        else begin res = '0; c = (amt == 32) ? rm[31] : 1'b0; end
                    end
                    2'b10: begin
                        if (amt < 32) begin res = $unsigned($signed(rm) >>> amt); c = rm[amt - 1]; end
                        else begin res = {32{rm[31]}}; c = rm[31]; end
                    end
                    default: begin
                        if ((amt % 32) == 0) begin
                            c = rm[31];
                        end else begin
                            res = (rm >> (amt % 32)) | (rm << (32 - (amt % 32)));
                            c   = res[31];
                        end
                    end
                endcase
            end
        end
        return {c, res};
    endfunction

    assign {bus.BS_SR29_OUT, bus.BS_Out} = bs_model(bus.BS_IR, bus.BS_Rm, bus.BS_Rs, bus.BS_SR29_IN);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    // Register-file responder: answers a request after ack_delay idle cycles,
    // drives junk data whenever it is not acknowledging.
    initial begin
        int wait_cnt;
        wait_cnt    = 0;
        bus.RF_Ack  = 1'b0;
        bus.RF_Data = 32'hDEAD_BEEF;
        forever begin
            @(negedge Clk);
            if (bus.RF_Req && ack_enable && !Reset) begin
                if (wait_cnt >= ack_delay) begin
                    bus.RF_Ack  = 1'b1;
                    bus.RF_Data = regs[bus.RF_Addr];
                    addr_log.push_back(bus.RF_Addr);
                    wait_cnt    = 0;
                end else begin
                    bus.RF_Ack  = 1'b0;
                    bus.RF_Data = 32'hDEAD_BEEF;
                    wait_cnt++;
                end
            end else begin
                bus.RF_Ack  = 1'b0;
                bus.RF_Data = 32'hDEAD_BEEF;
                wait_cnt    = 0;
            end
        end
    end

    // Issue one operation, scramble the inputs once accepted, then wait for Done
    // and compare against the scoreboard entry plus request/address bookkeeping.
    task automatic applyStimulus(input vec_t v, input bit pulse);
        int   lat;
        int   busy_cnt;
        int   req_cnt;
        bit   seen;
        exp_t e;
        addr_log.delete();
        ack_delay = v.ack_delay;
        @(negedge Clk);
        bus.IR_In   = v.ir;
        bus.SR29_In = v.c;
        bus.PC_In   = v.pc;
        bus.Start   = 1'b1;
        sb.push_back('{v.exp_operand, v.exp_carry, v.exp_error, v.exp_latency});
        lat = 0; busy_cnt = 0; req_cnt = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge Clk);
            lat++;
            bus.Start   = pulse;
            bus.IR_In   = 32'hFFFF_FFFF;
            bus.PC_In   = 32'hFFFF_0000;
            bus.SR29_In = ~v.c;
            if (bus.Busy)   busy_cnt++;
            if (bus.RF_Req) req_cnt++;
            if (bus.Done)   seen = 1'b1;
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            e = sb.pop_front();
            checkOutput("operand", bus.Operand, e.operand);
            checkOutput("carry", 32'(bus.CarryOut), 32'(e.carry));
            checkOutput("error", 32'(bus.Error), 32'(e.error));
            checkOutput("latency", lat, e.latency);
            checkOutput("busy_cycles", busy_cnt, e.latency);
            checkOutput("req_cycles", req_cnt, v.exp_req);
            checkOutput("addr_count", addr_log.size(), v.n_addr);
            if (addr_log.size() > 0 && v.n_addr > 0) checkOutput("addr0", 32'(addr_log[0]), 32'(v.addr0));
            if (addr_log.size() > 1 && v.n_addr > 1) checkOutput("addr1", 32'(addr_log[1]), 32'(v.addr1));
        end
        @(negedge Clk);
        bus.Start = 1'b0;
        checkOutput("idle_after_done", 32'(bus.Busy), 32'd0);
        checkOutput("done_one_cycle", 32'(bus.Done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_cnt;
        passed = 0; total = 0;
        for (int i = 0; i < 16; i++) regs[i] = 32'h0000_0100 + 32'(i);
        regs[1] = 32'h0000_0001; regs[2] = 32'h0000_0002; regs[3] = 32'h8000_0001;
        regs[4] = 32'h0000_0004; regs[5] = 32'hF000_0000; regs[6] = 32'h1234_5678;

        // ir, c, pc, ack_delay, operand, carry, error, latency, req cycles, n_addr, addr0, addr1
        vecs[0] = '{32'h0200_0000, 1'b1, 32'h0, 0, 32'h0000_0000, 1'b1, 1'b0, 2, 0, 0, 4'd0, 4'd0};
        vecs[1] = '{32'h0200_04FF, 1'b0, 32'h0, 0, 32'hFF00_0000, 1'b1, 1'b0, 2, 0, 0, 4'd0, 4'd0};
        vecs[2] = '{32'h0000_0112, 1'b0, 32'h0, 1, 32'h0000_0004, 1'b0, 1'b0, 6, 4, 2, 4'd2, 4'd1};
        vecs[3] = '{32'h0000_000F, 1'b1, 32'h0000_1000, 0, 32'h0000_1008, 1'b1, 1'b0, 3, 0, 0, 4'd0, 4'd0};
        vecs[4] = '{32'h0000_00A3, 1'b0, 32'h0, 2, 32'h4000_0000, 1'b1, 1'b0, 5, 3, 1, 4'd3, 4'd0};
        vecs[5] = '{32'h0000_0455, 1'b1, 32'h0, 0, 32'hFF00_0000, 1'b0, 1'b0, 4, 2, 2, 4'd5, 4'd4};
        vecs[6] = '{32'h0000_0F76, 1'b0, 32'h0000_0004, 1, 32'h6781_2345, 1'b0, 1'b0, 5, 2, 1, 4'd6, 4'd0};
        tmo_vec = '{32'h0000_0003, 1'b1, 32'h0, 0, 32'h0000_0000, 1'b1, 1'b1, ACK_TIMEOUT + 1, ACK_TIMEOUT, 0, 4'd0, 4'd0};

        ack_enable  = 1'b1;
        ack_delay   = 0;
        bus.Start   = 1'b0;
        bus.IR_In   = '0;
        bus.SR29_In = 1'b0;
        bus.PC_In   = '0;
        Reset       = 1'b1;
        repeat (2) @(negedge Clk);
        checkOutput("rst_busy", 32'(bus.Busy), 32'd0);
        checkOutput("rst_done", 32'(bus.Done), 32'd0);
        checkOutput("rst_req", 32'(bus.RF_Req), 32'd0);
        checkOutput("rst_addr", 32'(bus.RF_Addr), 32'd0);
        checkOutput("rst_operand", bus.Operand, 32'd0);
        checkOutput("rst_carry", 32'(bus.CarryOut), 32'd0);
        checkOutput("rst_error", 32'(bus.Error), 32'd0);
        checkOutput("rst_bs_ir", bus.BS_IR, 32'd0);
        checkOutput("rst_bs_rm", bus.BS_Rm, 32'd0);
        Reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], 1'b0);
            if (i == 3) begin
                checkOutput("r15_bs_rm", bus.BS_Rm, 32'h0000_1008);
                checkOutput("r15_bs_ir", bus.BS_IR, 32'h0000_000F);
            end
        end

        $display("[TB] read timeout");
        ack_enable = 1'b0;
        applyStimulus(tmo_vec, 1'b0);
        ack_enable = 1'b1;
        applyStimulus(vecs[2], 1'b0);

        $display("[TB] Start held during a register-shift op");
        applyStimulus(vecs[2], 1'b1);
        done_cnt = 0;
        repeat (6) begin
            @(negedge Clk);
            if (bus.Done || bus.Busy) done_cnt++;
        end
        checkOutput("no_queued_start", done_cnt, 0);

        $display("[TB] reset during a pending read");
        ack_enable = 1'b0;
        @(negedge Clk);
        bus.IR_In = 32'h0000_0112; bus.SR29_In = 1'b0; bus.PC_In = '0; bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        @(negedge Clk);
        checkOutput("req_before_reset", 32'(bus.RF_Req), 32'd1);
        #2 Reset = 1'b1;
        #1;
        checkOutput("reset_req", 32'(bus.RF_Req), 32'd0);
        checkOutput("reset_busy", 32'(bus.Busy), 32'd0);
        checkOutput("reset_operand", bus.Operand, 32'd0);
        done_cnt = 0;
        repeat (3) begin
            @(negedge Clk);
            if (bus.Done) done_cnt++;
        end
        checkOutput("reset_no_done", done_cnt, 0);
        Reset      = 1'b0;
        ack_enable = 1'b1;
        applyStimulus(vecs[5], 1'b0);

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shifter_operand_ctrl.md
Name: shifter_operand_ctrl

Overview:
Multi-cycle sequencer that builds the data-processing shifter operand for the CPU datapath. On Start it decodes the latched IR and fetches Rm, and Rs when needed, over the shared single register-file read port. It then drives the BarrelShifter for one cycle and registers the operand and shifter carry-out for the execute stage. Handshakes are Start/Busy/Done toward the control unit and Req/Ack toward the register file.

Parameters:
ACK_TIMEOUT, 15, max cycles to wait for RF_Ack per read before aborting (1..255)
PC_OFFSET, 8, added to PC_In when register index 15 is used

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  one-cycle request; sampled only in IDLE
IR_In  in  32  instruction word, latched on accepted Start
SR29_In  in  1  current C flag, latched on accepted Start
PC_In  in  32  current PC, latched on accepted Start
RF_Req  out  1  register-file read request
RF_Addr  out  4  register index for the read
RF_Ack  in  1  read data valid this cycle
RF_Data  in  32  read data
BS_Rs  out  32  to BarrelShifter Rs
BS_Rm  out  32  to BarrelShifter Rm
BS_IR  out  32  to BarrelShifter IR
BS_SR29_IN  out  1  to BarrelShifter SR29_IN
BS_Out  in  32  from BarrelShifter Out
BS_SR29_OUT  in  1  from BarrelShifter SR29_OUT
Operand  out  32  registered shifter operand
CarryOut  out  1  registered shifter carry
Done  out  1  one-cycle completion pulse
Error  out  1  valid with Done; read timed out
Busy  out  1  high whenever state != IDLE

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs and internal registers (ir_q, c_q, pc_q, rm_q, rs_q, timer) are 0.
- States: IDLE, READ_RM, READ_RS, SHIFT, DONE.
- IDLE:
  - On Start=1, latch IR_In, SR29_In and PC_In.
  - If IR_In[25]=1 (immediate form), go to SHIFT and use rm_q=rs_q=0.
  - Otherwise go to READ_RM.
  - Start=0 keeps the block in IDLE.
- READ_RM, index = ir_q[3:0]:
  - If index=15, set rm_q=pc_q+PC_OFFSET (mod 2^32) in one cycle with no RF_Req.
  - Otherwise drive RF_Req=1 and RF_Addr=index. On RF_Ack=1, latch RF_Data into rm_q.
  - Next state: READ_RS if ir_q[4]=1, else SHIFT (rs_q=0).
- READ_RS, index = ir_q[11:8]: same rules as READ_RM, latching into rs_q. Next state is SHIFT.
- RF_Req is combinational from state and is deasserted in the cycle after Ack. RF_Addr is 0 when RF_Req=0.
- Timeout:
  - timer clears on entry to each READ state and increments every cycle without Ack.
  - If timer reaches ACK_TIMEOUT with no Ack, go to DONE with Error=1, Operand=0, CarryOut=c_q.
  - Ack in the same cycle the limit is reached wins.
- BS_* outputs:
  - BS_IR=ir_q, BS_Rm=rm_q, BS_Rs=rs_q, BS_SR29_IN=c_q, held constant from SHIFT through DONE.
  - In IDLE they hold their last values.
- SHIFT: one cycle. At its end, capture BS_Out into Operand and BS_SR29_OUT into CarryOut, then go to DONE.
- DONE: Done=1 for exactly one cycle, Error as set above, then return to IDLE. Operand, CarryOut and Error hold until the next capture.
- Start while Busy=1 (including DONE) is ignored and not queued.
- Latency from the Start edge to the Done cycle:
  - immediate: 2 cycles
  - register: 3 + ack wait
  - register-shift: 4 + ack waits
  - index 15 reads add no wait.
- A stray RF_Ack outside the READ states is ignored.
- Reset mid-operation aborts immediately: RF_Req drops asynchronously and no Done is emitted.

Test Plan:
- Reset, then IR_In=0x02000000 (imm), Start 1 cycle -> no RF_Req; Done exactly 2 cycles after Start; Operand=BarrelShifter result for that IR; Busy high 2 cycles.
- IR_In=0x00000112 (Rm=r2, LSL by Rs=r1), r2=0x00000002, r1=0x00000001, Ack 1 cycle after each Req -> RF_Addr 2 then 1; Operand=0x00000004, CarryOut=0, Done at cycle 6.
- IR_In=0x0000000F (Rm=r15), PC_In=0x00001000 -> no RF_Req; BS_Rm=0x00001008; Done 3 cycles after Start.
- Register form, RF_Ack never asserted, ACK_TIMEOUT=15 -> RF_Req held 15 cycles, then Done=1 with Error=1 and Operand=0; next Start proceeds normally with Error=0.
- Start pulsed every cycle during a register-shift op -> exactly one Done; RF_Addr sequence unchanged.
- Reset asserted while RF_Req=1 -> RF_Req, Busy and Operand go 0 immediately with no Done; Start after reset release completes normally.
